// File: rtl/pill_dispense_scheduler.sv
// Dispense sequencer for three pill compartments: latches due pills on the hour,
// alarms the user, then grants the shared motor round-robin. Optional macro: SNOOZE_EN.
module pill_dispense_scheduler #(
    parameter int unsigned MISS_HOURS   = 2,
    parameter logic [3:0]  RUN_STATE    = 4'd3
`ifdef SNOOZE_EN
    ,
    parameter int unsigned SNOOZE_HOURS = 1
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  state,
    input  logic [11:0] pill12And3Duration,
    input  logic        hourTick,
    input  logic        userAck,
    input  logic        dispenserReady,
`ifdef SNOOZE_EN
    input  logic        snooze,
`endif
    output logic        alarm,
    output logic        dispenseValid,
    output logic [1:0]  dispenseSlot,
    output logic [2:0]  pendingMask,
    output logic [7:0]  missedCount
);

    typedef enum logic [2:0] {
        IDLE,
        ALARM,
        GRANT,
        WAIT,
        GAP
`ifdef SNOOZE_EN
        ,
        SNOOZE
`endif
    } fsmState_t;

    fsmState_t  fsmState;
    logic [1:0] rrPtr;
    logic [3:0] hourTimer;
`ifdef SNOOZE_EN
    logic [3:0] snoozeTimer;
`endif

    logic       runMode;
    logic [2:0] dueMask;
    logic       timerDone;
    logic       missTimeout;
    logic       handshake;
    logic [2:0] clearMask;
    logic [1:0] pendingCount;
    logic [8:0] missedSum;
    logic [1:0] grantSlot;

    // Search order starts at the round-robin pointer and wraps 2 -> 0.
    function automatic logic [1:0] pickSlot(input logic [2:0] mask, input logic [1:0] ptr);
        logic [1:0] s0, s1, s2;
        case (ptr)
            2'd1:    begin s0 = 2'd1; s1 = 2'd2; s2 = 2'd0; end
            2'd2:    begin s0 = 2'd2; s1 = 2'd0; s2 = 2'd1; end
            default: begin s0 = 2'd0; s1 = 2'd1; s2 = 2'd2; end
        endcase
        if (mask[s0])      return s0;
        else if (mask[s1]) return s1;
        else               return s2;
    endfunction

    assign runMode      = (state == RUN_STATE);
    assign dueMask      = (hourTick && runMode) ?
                          {pill12And3Duration[3:0] == 4'd0,
                           pill12And3Duration[7:4] == 4'd0,
                           pill12And3Duration[11:8] == 4'd0} : 3'b000;
    assign timerDone    = ({1'b0, hourTimer} + 5'd1) >= 5'(MISS_HOURS);
    assign handshake    = (fsmState == WAIT) && dispenserReady;
    assign pendingCount = {1'b0, pendingMask[0]} + {1'b0, pendingMask[1]} + {1'b0, pendingMask[2]};
    assign missedSum    = {1'b0, missedCount} + {7'b0, pendingCount};
    assign grantSlot    = pickSlot(pendingMask, rrPtr);

    // A timeout is the tick that would push the hour timer to MISS_HOURS while unacknowledged.
    always_comb begin
        missTimeout = 1'b0;
        if (hourTick && runMode && timerDone) begin
            if (fsmState == ALARM && !userAck) missTimeout = 1'b1;
`ifdef SNOOZE_EN
            if (fsmState == SNOOZE) missTimeout = 1'b1;
`endif
        end
    end

    always_comb begin
        clearMask = 3'b000;
        if (missTimeout)    clearMask = 3'b111;
        else if (handshake) clearMask = 3'b001 << dispenseSlot;
    end

    // Pending bits: new due pills are OR-ed in after clearing, so a same-cycle set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendingMask <= 3'b000;
            missedCount <= 8'd0;
        end else begin
            pendingMask <= (pendingMask & ~clearMask) | dueMask;
            if (missTimeout)
                missedCount <= missedSum[8] ? 8'hFF : missedSum[7:0];
        end
    end

    // Main sequencer; all outputs are registered alongside the state transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsmState      <= IDLE;
            alarm         <= 1'b0;
            dispenseValid <= 1'b0;
            dispenseSlot  <= 2'd0;
            rrPtr         <= 2'd0;
            hourTimer     <= 4'd0;
`ifdef SNOOZE_EN
            snoozeTimer   <= 4'd0;
`endif
        end else begin
            case (fsmState)
                IDLE: begin
                    alarm <= 1'b0;
                    if (pendingMask != 3'b000 && runMode) begin
                        fsmState  <= ALARM;
                        alarm     <= 1'b1;
                        hourTimer <= 4'd0;
                    end
                end
                ALARM: begin
                    if (!runMode) begin
                        fsmState <= IDLE;
                        alarm    <= 1'b0;
                    end else if (userAck) begin
                        fsmState <= GRANT;
                        alarm    <= 1'b0;
                    end else if (missTimeout) begin
                        fsmState <= IDLE;
                        alarm    <= 1'b0;
                    end else begin
                        if (hourTick) hourTimer <= hourTimer + 4'd1;
`ifdef SNOOZE_EN
                        if (snooze) begin
                            fsmState    <= SNOOZE;
                            alarm       <= 1'b0;
                            snoozeTimer <= 4'd0;
                        end
`endif
                    end
                end
`ifdef SNOOZE_EN
                SNOOZE: begin
                    alarm <= 1'b0;
                    if (!runMode || missTimeout) begin
                        fsmState <= IDLE;
                    end else if (hourTick) begin
                        hourTimer <= hourTimer + 4'd1;
                        if (({1'b0, snoozeTimer} + 5'd1) >= 5'(SNOOZE_HOURS)) begin
                            fsmState <= ALARM;
                            alarm    <= 1'b1;
                        end else begin
                            snoozeTimer <= snoozeTimer + 4'd1;
                        end
                    end
                end
`endif
                GRANT: begin
                    alarm <= 1'b0;
                    if (pendingMask == 3'b000) begin
                        fsmState <= IDLE;
                    end else begin
                        dispenseValid <= 1'b1;
                        dispenseSlot  <= grantSlot;
                        fsmState      <= WAIT;
                    end
                end
                WAIT: begin
                    if (dispenserReady) begin
                        dispenseValid <= 1'b0;
                        rrPtr         <= (dispenseSlot == 2'd2) ? 2'd0 : dispenseSlot + 2'd1;
                        fsmState      <= GAP;
                    end
                end
                GAP: begin
                    if (pendingMask != 3'b000 && runMode) fsmState <= GRANT;
                    else                                  fsmState <= IDLE;
                end
                default: begin
                    fsmState      <= IDLE;
                    alarm         <= 1'b0;
                    dispenseValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pill_dispense_scheduler.sv
// Directed bench for pill_dispense_scheduler: dispensed slots are checked against a
// scoreboard queue, everything else against expectations derived per step.
module tb_pill_dispense_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [11:0] pill12And3Duration;
    logic        hourTick;
    logic        userAck;
    logic        dispenserReady;
`ifdef SNOOZE_EN
    logic        snooze;
`endif
    logic        alarm;
    logic        dispenseValid;
    logic [1:0]  dispenseSlot;
    logic [2:0]  pendingMask;
    logic [7:0]  missedCount;

    int          checks = 0;
    int          failures = 0;
    logic [1:0]  expectedSlots[$];
    int          missedModel = 0;

    localparam logic [3:0] RUN = 4'd3;

    always #5 clk = ~clk;

    pill_dispense_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .state              (state),
        .pill12And3Duration (pill12And3Duration),
        .hourTick           (hourTick),
        .userAck            (userAck),
        .dispenserReady     (dispenserReady),
`ifdef SNOOZE_EN
        .snooze             (snooze),
`endif
        .alarm              (alarm),
        .dispenseValid      (dispenseValid),
        .dispenseSlot       (dispenseSlot),
        .pendingMask        (pendingMask),
        .missedCount        (missedCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then returns just after the edge that sampled them.
    task automatic applyStimulus(input logic [3:0] st, input logic [11:0] dur,
                                 input logic tick, input logic ack, input logic rdy);
        state              = st;
        pill12And3Duration = dur;
        hourTick           = tick;
        userAck            = ack;
        dispenserReady     = rdy;
        @(posedge clk);
        #1;
    endtask

    // Handshakes are seen at the falling edge before the capturing rising edge.
    always @(negedge clk) begin
        if (!reset && dispenseValid && dispenserReady) begin
            if (expectedSlots.size() == 0) begin
                checkOutput("unexpectedHandshake", 32'd1, 32'd0);
            end else begin
                checkOutput("handshakeSlot", {30'd0, dispenseSlot}, {30'd0, expectedSlots.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
`ifdef SNOOZE_EN
        snooze = 1'b0;
`endif
        applyStimulus(4'd0, 12'h111, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd0, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("resetAlarm", {31'd0, alarm}, 32'd0);
        checkOutput("resetValid", {31'd0, dispenseValid}, 32'd0);
        checkOutput("resetSlot", {30'd0, dispenseSlot}, 32'd0);
        checkOutput("resetPending", {29'd0, pendingMask}, 32'd0);
        checkOutput("resetMissed", {24'd0, missedCount}, 32'd0);
        reset = 1'b0;

        $display("[TB] two pills due, acknowledged and dispensed in order");
        applyStimulus(RUN, 12'h030, 1'b1, 1'b0, 1'b0);
        checkOutput("dueMask101", {29'd0, pendingMask}, 32'b101);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("alarmRaised", {31'd0, alarm}, 32'd1);
        expectedSlots.push_back(2'd0);
        expectedSlots.push_back(2'd2);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b1, 1'b0);
        checkOutput("validAfterAck1", {31'd0, dispenseValid}, 32'd0);
        checkOutput("alarmOffAtGrant", {31'd0, alarm}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b1);
        checkOutput("validAfterAck2", {31'd0, dispenseValid}, 32'd1);
        checkOutput("firstSlot", {30'd0, dispenseSlot}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b1);
        checkOutput("pendingAfterSlot0", {29'd0, pendingMask}, 32'b100);
        checkOutput("validLowInGap", {31'd0, dispenseValid}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b1);
        checkOutput("validLowGrant", {31'd0, dispenseValid}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b1);
        checkOutput("secondValid", {31'd0, dispenseValid}, 32'd1);
        checkOutput("secondSlot", {30'd0, dispenseSlot}, 32'd2);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b1);
        checkOutput("pendingDrained", {29'd0, pendingMask}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("idleAlarm", {31'd0, alarm}, 32'd0);
        checkOutput("idleValid", {31'd0, dispenseValid}, 32'd0);

        $display("[TB] unacknowledged alarm times out");
        applyStimulus(RUN, 12'h101, 1'b1, 1'b0, 1'b0);
        checkOutput("duePill2", {29'd0, pendingMask}, 32'b010);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("alarmPill2", {31'd0, alarm}, 32'd1);
        applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
        checkOutput("alarmAfterTick1", {31'd0, alarm}, 32'd1);
        checkOutput("missedAfterTick1", {24'd0, missedCount}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
        missedModel = missedModel + 1;
        checkOutput("missedAfterTimeout", {24'd0, missedCount}, missedModel);
        checkOutput("pendingAfterTimeout", {29'd0, pendingMask}, 32'd0);
        checkOutput("alarmAfterTimeout", {31'd0, alarm}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("stillIdle", {31'd0, alarm}, 32'd0);

        $display("[TB] dispenser stalls for ten cycles");
        applyStimulus(RUN, 12'h110, 1'b1, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        expectedSlots.push_back(2'd2);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b1, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("stallGrant", {31'd0, dispenseValid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
            checkOutput("stallValid", {31'd0, dispenseValid}, 32'd1);
            checkOutput("stallSlot", {30'd0, dispenseSlot}, 32'd2);
        end
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b1);
        checkOutput("stallCleared", {29'd0, pendingMask}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);

        $display("[TB] pill 1 re-armed on its own handshake cycle");
        applyStimulus(RUN, 12'h011, 1'b1, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        expectedSlots.push_back(2'd0);
        expectedSlots.push_back(2'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b1, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("rearmFirstSlot", {30'd0, dispenseSlot}, 32'd0);
        applyStimulus(RUN, 12'h011, 1'b1, 1'b0, 1'b1);
        checkOutput("setWinsOverClear", {29'd0, pendingMask}, 32'b001);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b1);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b1);
        checkOutput("rearmValid", {31'd0, dispenseValid}, 32'd1);
        checkOutput("rearmSlot", {30'd0, dispenseSlot}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b1);
        checkOutput("rearmCleared", {29'd0, pendingMask}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);

        $display("[TB] missed counter climbs to saturation");
        for (int i = 0; i < 84; i++) begin
            applyStimulus(RUN, 12'h000, 1'b1, 1'b0, 1'b0);
            applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
            applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
            applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
            missedModel = (missedModel + 3 > 255) ? 255 : missedModel + 3;
            checkOutput("missedClimb", {24'd0, missedCount}, missedModel);
        end
        applyStimulus(RUN, 12'h101, 1'b1, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
        missedModel = missedModel + 1;
        checkOutput("missedAt254", {24'd0, missedCount}, 32'd254);
        applyStimulus(RUN, 12'h100, 1'b1, 1'b0, 1'b0);
        checkOutput("twoDue", {29'd0, pendingMask}, 32'b110);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
        missedModel = 255;
        checkOutput("missedSaturated", {24'd0, missedCount}, missedModel);

        $display("[TB] leaving run mode during the alarm");
        applyStimulus(RUN, 12'h011, 1'b1, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("modeAlarm", {31'd0, alarm}, 32'd1);
        applyStimulus(4'd0, 12'h000, 1'b0, 1'b0, 1'b0);
        checkOutput("modeExitAlarm", {31'd0, alarm}, 32'd0);
        checkOutput("modeExitPending", {29'd0, pendingMask}, 32'b001);
        applyStimulus(4'd0, 12'h000, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd0, 12'h000, 1'b0, 1'b0, 1'b0);
        checkOutput("noDueOutOfRun", {29'd0, pendingMask}, 32'b001);
        checkOutput("noAlarmOutOfRun", {31'd0, alarm}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("alarmResumed", {31'd0, alarm}, 32'd1);

        $display("[TB] reset asserted mid-transfer");
        expectedSlots.push_back(2'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b1, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("preResetValid", {31'd0, dispenseValid}, 32'd1);
        checkOutput("preResetMissed", {24'd0, missedCount}, missedModel);
        reset = 1'b1;
        expectedSlots.delete();
        missedModel = 0;
        #2;
        checkOutput("asyncResetValid", {31'd0, dispenseValid}, 32'd0);
        checkOutput("asyncResetSlot", {30'd0, dispenseSlot}, 32'd0);
        checkOutput("asyncResetPending", {29'd0, pendingMask}, 32'd0);
        checkOutput("asyncResetMissed", {24'd0, missedCount}, missedModel);
        checkOutput("asyncResetAlarm", {31'd0, alarm}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("postResetIdle", {31'd0, alarm}, 32'd0);

`ifdef SNOOZE_EN
        $display("[TB] snooze defers the alarm by one hour");
        applyStimulus(RUN, 12'h011, 1'b1, 1'b0, 1'b0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("snoozeAlarmUp", {31'd0, alarm}, 32'd1);
        snooze = 1'b1;
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        snooze = 1'b0;
        checkOutput("snoozeAlarmOff", {31'd0, alarm}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
        checkOutput("snoozeStillOff", {31'd0, alarm}, 32'd0);
        applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
        checkOutput("snoozeAlarmBack", {31'd0, alarm}, 32'd1);
        applyStimulus(RUN, 12'h111, 1'b1, 1'b0, 1'b0);
        missedModel = missedModel + 1;
        checkOutput("snoozeTimeout", {24'd0, missedCount}, missedModel);
        applyStimulus(RUN, 12'h111, 1'b0, 1'b0, 1'b0);
`endif

        checkOutput("scoreboardDrained", expectedSlots.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pill_dispense_scheduler.md
Name: pill_dispense_scheduler

Overview:
- Sequences dispensing for the three pill compartments, driven by the 12-bit packed countdown bus from the next-pill monitor (pill1 [11:8], pill2 [7:4], pill3 [3:0]).
- On each hour boundary, latches which pills are due and raises the user alarm.
- After the user acknowledges, grants the single shared dispenser motor to one due compartment at a time (round-robin), using a valid/ready handshake.
- Counts doses missed through alarm timeout.

Parameters:
- MISS_HOURS, 2: hour ticks an unacknowledged alarm may stay up before its doses are declared missed (1..15).
- RUN_STATE, 4'd3: value of the system state bus that means normal running mode.
- SNOOZE_HOURS, 1: hour ticks an alarm is deferred per snooze; used only with SNOOZE_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- state  in  4  system control state; scheduling is active only when state == RUN_STATE
- pill12And3Duration  in  12  packed hours-remaining per pill, 4 bits each
- hourTick  in  1  single-cycle pulse on each hour rollover
- userAck  in  1  user acknowledge button, already synchronised and debounced, level
- dispenserReady  in  1  dispenser accepts the current slot this cycle
- alarm  out  1  buzzer/LED request
- dispenseValid  out  1  slot request to the dispenser
- dispenseSlot  out  2  compartment 0..2 being requested; 3 never driven
- pendingMask  out  3  due-but-not-dispensed pills; bit i = pill i+1
- missedCount  out  8  saturating count of missed doses
- snooze  in  1  snooze request; port exists only with SNOOZE_EN

Behaviour:
- Reset (async): all outputs are 0; FSM goes to IDLE; round-robin pointer = 0; hour timer = 0.
- Due detection:
  - On a cycle with hourTick=1 and state==RUN_STATE, set pendingMask[i] for each pill whose nibble == 0.
  - The nibble is sampled in that same cycle. pendingMask is visible the next cycle.
- Set/clear collision: if a bit is set and cleared in the same cycle, set wins.
- FSM states: IDLE, ALARM, GRANT, WAIT, GAP.
- IDLE:
  - alarm=0.
  - If pendingMask!=0 and state==RUN_STATE: go to ALARM and clear the hour timer.
- ALARM:
  - alarm=1.
  - userAck=1: go to GRANT next cycle.
  - Otherwise, each hourTick increments the hour timer. When it reaches MISS_HOURS:
    - missedCount += popcount(pendingMask), saturating at 255.
    - pendingMask cleared, except bits newly set by that same tick.
    - Go to IDLE.
  - If userAck and the final timeout tick occur in the same cycle, userAck wins.
- GRANT:
  - Pick the first set pending bit, searching from the pointer upward and wrapping 2→0.
  - Drive dispenseSlot with that index and dispenseValid=1. Go to WAIT.
  - alarm=0 from GRANT onward.
- WAIT:
  - dispenseValid and dispenseSlot are held stable until dispenserReady=1.
  - On the handshake cycle: clear that pending bit; pointer = slot+1 mod 3; dispenseValid=0 next cycle; go to GAP.
- GAP:
  - One idle cycle, so the dispenser sees valid low between grants.
  - If pendingMask!=0, go to GRANT (no second ack needed). Otherwise go to IDLE.
- Latency: userAck to first dispenseValid is 2 cycles. Consecutive grants are spaced by a minimum of 3 cycles.
- Mode exit (state!=RUN_STATE):
  - In ALARM: go to IDLE next cycle; pendingMask retained.
  - In GRANT/WAIT/GAP: the current transfer completes, then go to IDLE.
  - No new due detection while out of run mode.
- Reset asserted mid-transfer drops dispenseValid immediately (async).

Optional Feature:
- Macro: SNOOZE_EN.
- With SNOOZE_EN defined:
  - snooze=1 in ALARM moves the FSM to a SNOOZE state with alarm=0.
  - SNOOZE returns to ALARM after SNOOZE_HOURS hourTicks.
  - The hour timer keeps counting through SNOOZE, so missed-dose timeout still applies.
  - snooze and userAck together: userAck wins.
- Without SNOOZE_EN: the snooze port and SNOOZE state are absent; behaviour is exactly as above.

Test Plan:
- Nibbles 0x0,0x3,0x0 with hourTick in run mode → pendingMask=3'b101 next cycle and alarm=1. userAck → dispenseSlot=0 two cycles later; with ready high, slot 2 is granted 3 cycles after the slot-0 handshake; pendingMask ends 0 and alarm=0.
- Alarm raised for pill 2 only, no ack, MISS_HOURS=2 → after the 2nd hourTick, missedCount=1, pendingMask=0, FSM in IDLE.
- dispenserReady held low for 10 cycles during WAIT → dispenseValid=1 and dispenseSlot unchanged for all 10 cycles; the handshake on cycle 11 clears the bit.
- missedCount preset to 254, a timeout with 2 pending pills → missedCount=255 (saturates).
- hourTick re-sets pill 1's bit on the same cycle its handshake clears it → bit remains 1 and pill 1 is granted again after GAP.
- With SNOOZE_EN, snooze in ALARM, SNOOZE_HOURS=1 → alarm=0 until the next hourTick, then alarm=1.
- Assert reset during WAIT → all outputs 0 asynchronously.
